// File: rtl/pipe_cla_addsub_if.sv
// Operand/result handshake bundle for pipe_cla_addsub.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipe_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic             Zero;

  modport master (
    output in_valid, A, B, Cin, op, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf, Zero
  );

  modport slave (
    input  in_valid, A, B, Cin, op, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf, Zero
  );
endinterface

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/sub/sbb, one GROUP-bit lookahead group per stage; latency WIDTH/GROUP cycles.
// Bubble-collapsing valid/ready: in_ready drops only when every stage holds a stalled result.
module pipe_cla_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_cla_addsub_if.slave bus
);

  localparam int NSTG = WIDTH / GROUP;
  localparam int LST  = NSTG - 1;
  localparam int MSB  = WIDTH - 1;

  if ((GROUP < 2) || ((WIDTH % GROUP) != 0)) begin : g_cfg_bad
    $fatal(1, "pipe_cla_addsub: WIDTH must be a multiple of GROUP and GROUP must be >= 2");
  end

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SBB = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  logic             vld_q [NSTG];
  logic             vld_d [NSTG];
  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] a_d   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] b_d   [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [WIDTH-1:0] sum_d [NSTG];
  logic             cy_q  [NSTG];
  logic             cy_d  [NSTG];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             run_q, run_d;

  logic [NSTG-1:0]  load;
  logic             in_rdy;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] src_a, src_b, src_s;
  logic             src_c, src_v;
  logic [GROUP:0]   grp;

  // Returns {carry_out, sum} of one group; every internal carry is a flat
  // generate/propagate product term rather than a ripple chain.
  function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                               input logic [GROUP-1:0] b,
                                               input logic             c0);
    logic [GROUP-1:0] g, p;
    logic [GROUP:0]   c;
    logic             term, pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < GROUP; i++) begin
      term = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g[j]);
        pp   = pp & p[j];
      end
      c[i+1] = term | (pp & c0);
    end
    return {c[GROUP], p ^ c[GROUP-1:0]};
  endfunction

  always_comb begin
    run_d   = 1'b1;
    b_eff   = ((bus.op == OP_SUB) || (bus.op == OP_SBB)) ? ~bus.B : bus.B;
    cin_eff = (bus.op == OP_SUB) ? 1'b1 : bus.Cin;

    // A stage may load when empty or when the stage after it is moving.
    load       = '0;
    load[LST]  = ~vld_q[LST] | bus.out_ready;
    for (int k = LST - 1; k >= 0; k--) begin
      load[k] = ~vld_q[k] | load[k+1];
    end
    in_rdy = run_q & load[0];

    ovf_d  = ovf_q;
    zero_d = zero_q;
    src_a  = '0;
    src_b  = '0;
    src_s  = '0;
    src_c  = 1'b0;
    src_v  = 1'b0;
    grp    = '0;

    for (int k = 0; k < NSTG; k++) begin
      vld_d[k] = vld_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
      cy_d[k]  = cy_q[k];

      if (k == 0) begin
        src_a = bus.A;
        src_b = b_eff;
        src_s = '0;
        src_c = cin_eff;
        src_v = bus.in_valid & in_rdy;
      end else begin
        src_a = a_q[(k == 0) ? 0 : k - 1];
        src_b = b_q[(k == 0) ? 0 : k - 1];
        src_s = sum_q[(k == 0) ? 0 : k - 1];
        src_c = cy_q[(k == 0) ? 0 : k - 1];
        src_v = vld_q[(k == 0) ? 0 : k - 1];
      end

      grp = cla_group(src_a[k*GROUP +: GROUP], src_b[k*GROUP +: GROUP], src_c);

      if (load[k]) begin
        vld_d[k] = src_v;
      end
      // Payload only moves with a valid item so a stalled or idle output never changes.
      if (load[k] && src_v) begin
        a_d[k]                     = src_a;
        b_d[k]                     = src_b;
        sum_d[k]                   = src_s;
        sum_d[k][k*GROUP +: GROUP] = grp[GROUP-1:0];
        cy_d[k]                    = grp[GROUP];
        if (k == LST) begin
          zero_d = ~|sum_d[k];
          ovf_d  = (src_a[MSB] == src_b[MSB]) && (sum_d[k][MSB] != src_a[MSB]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
    end else begin
      run_q  <= run_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= vld_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
        cy_q[k]  <= cy_d[k];
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q[LST];
  assign bus.Sum       = sum_q[LST];
  assign bus.Cout      = cy_q[LST];
  assign bus.Ovf       = ovf_q;
  assign bus.Zero      = zero_q;

endmodule

// File: doc/pipe_cla_addsub.md
PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter GROUP, default 8: carry-lookahead group width; one group is resolved per pipeline stage.
REQ-003 Derived NSTG = WIDTH/GROUP; WIDTH SHALL be a multiple of GROUP, GROUP SHALL be >= 2, and elaboration SHALL fail otherwise.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand set present on A/B/Cin/op.
REQ-007 in_ready  output  1  block accepts the operand set this cycle.
REQ-008 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 B  input  WIDTH  operand B.
REQ-010 Cin  input  1  carry in, used by ADD and SBB only.
REQ-011 op  input  2  00 ADD, 01 SUB, 10 SBB, 11 reserved (executes as ADD).
REQ-012 out_valid  output  1  result present on Sum/Cout/Ovf/Zero.
REQ-013 out_ready  input  1  downstream accepts the result this cycle.
REQ-014 Sum  output  WIDTH  result.
REQ-015 Cout  output  1  carry out of the MSB; for SUB/SBB, 1 means no borrow.
REQ-016 Ovf  output  1  signed overflow.
REQ-017 Zero  output  1  Sum is all zeros.

Function
REQ-018 The block SHALL compute the following, with B' = ~B for SUB/SBB and B' = B otherwise: ADD = A+B+Cin; SUB = A+~B+1; SBB = A+~B+Cin.
REQ-019 Each stage k (0..NSTG-1) SHALL compute generate/propagate and lookahead sum for bits [k*GROUP +: GROUP] using the carry registered by stage k-1 (stage 0 uses the effective cin).
REQ-020 Each stage k SHALL forward the upper operand bits and the lower result bits to the next stage unmodified.
REQ-021 Each stage SHALL hold a valid bit; a stage SHALL load when it is empty or when its downstream neighbour loads (bubble-collapsing).
REQ-022 The last stage SHALL drain when out_valid && out_ready.
REQ-023 in_ready SHALL equal the stage-0 load condition, combinational from the stage valid bits and out_ready, with no path from in_valid.
REQ-024 Transfer occurs on in_valid && in_ready; there SHALL be no transfer when in_valid=0.
REQ-025 Latency SHALL be NSTG cycles from accept to out_valid when there is no backpressure.
REQ-026 Throughput SHALL be 1 result per cycle with out_ready held at 1.
REQ-027 While out_valid=1 and out_ready=0, Sum/Cout/Ovf/Zero SHALL hold stable.
REQ-028 Under stall, upstream bubbles SHALL fill; in_ready SHALL drop only when all NSTG stages are valid.
REQ-029 Results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-030 Ovf SHALL equal (A[MSB]==B'[MSB]) && (Sum[MSB]!=A[MSB]).
REQ-031 Zero SHALL equal ~|Sum.
REQ-032 Cout SHALL be the carry out of bit WIDTH-1 of the WIDTH-bit add; Sum SHALL wrap modulo 2^WIDTH.
REQ-033 All outputs SHALL be driven from the registers of the last stage, with no combinational path from A/B to the outputs.
REQ-034 op and Cin SHALL be sampled at accept; subsequent changes SHALL NOT affect in-flight items.

Reset
REQ-035 On rst_n=0, all stage valid bits SHALL clear immediately, regardless of the clock.
REQ-036 During reset, out_valid, Sum, Cout, Ovf and Zero SHALL all be 0.
REQ-037 in_ready SHALL be 0 while rst_n=0 and SHALL be 1 on the first cycle after deassertion.
REQ-038 Reset mid-operation SHALL discard all in-flight items; no stale result SHALL appear after release.
REQ-039 Reset deassertion SHALL be honoured synchronously to clk (release takes effect at a clock edge).

Verification (WIDTH=16, GROUP=8, NSTG=2)
REQ-040 ADD 69+42, Cin=0, out_ready=1 -> 2 cycles later Sum=111, Cout=0, Ovf=0, Zero=0; repeating with Cin=1 -> Sum=112.
REQ-041 ADD 0x8000+0x8000, Cin=0 -> Sum=0x0000, Cout=1, Ovf=1, Zero=1; ADD 0x00FF+0x0001 (carry crossing groups) -> Sum=0x0100, Cout=0.
REQ-042 SUB 5-7 -> Sum=0xFFFE, Cout=0, Ovf=0; SUB 0x8000-1 -> Sum=0x7FFF, Cout=1, Ovf=1; SBB 7-5 with Cin=0 -> Sum=1.
REQ-043 Back-to-back stream of 8 random operand sets, out_ready=1 -> 8 consecutive out_valid cycles, matching the reference model and in order.
REQ-044 Stall test: hold out_ready=0 with input streaming -> in_ready drops after 2 accepts and outputs stay stable; release out_ready -> both results drain in order, then 1/cycle resumes.
REQ-045 Assert rst_n=0 mid-clock with 2 items in flight -> out_valid=0 immediately; after release, no output until a new accept, and in_ready=1.
